// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared widths, opcodes and fetch-state encoding for the 5-stage pipeline
package pipeline_pkg;
    localparam int IW    = 12;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam logic [3:0] ADD = 4'h0;
    localparam logic [3:0] SUB = 4'h1;
    localparam logic [3:0] MUL = 4'h2;
    localparam logic [3:0] DIV = 4'h3;
    typedef enum logic [1:0] {IDLE, RUN, DONE} fetch_state_e;
endpackage

// File: rtl/instr_store.sv
// instr_store: DEPTH x IW instruction array, synchronous write, asynchronous read
// ports: clk, we/waddr/wdata write port, raddr/rdata combinational read port
module instr_store
    import pipeline_pkg::*;
(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);
    logic [IW-1:0] mem_q [DEPTH];
    always_ff @(posedge clk)
        if (we) mem_q[waddr] <= wdata;
    assign rdata = mem_q[raddr];
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: loadable instruction store with PC sequencer and valid/ready output register
// ports: clk, rst_n (sync, active-low); load_en/load_addr/load_data program loading;
//        start, redirect_valid/redirect_pc control; instr_ready back-pressure;
//        instr_valid/instr_out/pc_out fetch output; busy, done, prog_len status
module instr_fetch_unit
    import pipeline_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [IW-1:0] load_data,
    input  logic          start,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    input  logic          instr_ready,
    output logic          instr_valid,
    output logic [IW-1:0] instr_out,
    output logic [AW-1:0] pc_out,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   prog_len
);
    fetch_state_e  state_q, state_d;
    logic [AW:0]   pc_q, pc_d, len_q, len_d, load_len;
    logic          valid_q, valid_d, store_we;
    logic [IW-1:0] instr_q, instr_d, rdata;
    logic [AW-1:0] pcout_q, pcout_d;

    // loads are only accepted outside RUN so a running program is never altered
    assign store_we = load_en && state_q != RUN;
    assign load_len = (AW+1)'(load_addr) + 1'b1;

    // PC only reaches the store while below prog_len <= DEPTH, so its low bits suffice
    instr_store u_store (
        .clk   (clk),
        .we    (store_we),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc_q[AW-1:0]),
        .rdata (rdata)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        valid_d = valid_q;
        instr_d = instr_q;
        pcout_d = pcout_q;
        if (state_q != RUN) begin
            if (load_en) begin
                len_d   = load_len > len_q ? load_len : len_q;
                state_d = IDLE;
            end else if (start) begin
                state_d = len_q != 0 ? RUN : DONE;
                pc_d    = '0;
            end
        end else if (redirect_valid) begin
            valid_d = 1'b0;
            if ({1'b0, redirect_pc} < len_q) pc_d = {1'b0, redirect_pc};
            else state_d = DONE;
        end else if (!valid_q || instr_ready) begin
            if (pc_q < len_q) begin
                instr_d = rdata;
                pcout_d = pc_q[AW-1:0];
                valid_d = 1'b1;
                pc_d    = pc_q + 1'b1;
            end else begin
                valid_d = 1'b0;
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            pcout_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            pcout_q <= pcout_d;
        end
    end

    assign instr_valid = valid_q;
    assign instr_out   = instr_q;
    assign pc_out      = pcout_q;
    assign busy        = state_q == RUN;
    assign done        = state_q == DONE;
    assign prog_len    = len_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        load_en = 0;
    logic [3:0]  load_addr = 0;
    logic [11:0] load_data = 0;
    logic        start = 0;
    logic        redirect_valid = 0;
    logic [3:0]  redirect_pc = 0;
    logic        instr_ready = 1;
    logic        instr_valid;
    logic [11:0] instr_out;
    logic [3:0]  pc_out;
    logic        busy;
    logic        done;
    logic [4:0]  prog_len;
    int          n_tests = 0;
    int          n_fail = 0;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_en        (load_en),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .start          (start),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_ready    (instr_ready),
        .instr_valid    (instr_valid),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .busy           (busy),
        .done           (done),
        .prog_len       (prog_len)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_word(input logic [3:0] a, input logic [11:0] d);
        load_en = 1; load_addr = a; load_data = d;
        tick();
        load_en = 0;
    endtask

    task automatic do_start();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic expect_instr(input string tag, input logic [11:0] d, input logic [3:0] p);
        check({tag, ".valid"}, instr_valid, 1);
        check({tag, ".instr"}, instr_out, d);
        check({tag, ".pc"}, pc_out, p);
    endtask

    task automatic expect_done(input string tag);
        check({tag, ".valid"}, instr_valid, 0);
        check({tag, ".done"}, done, 1);
        check({tag, ".busy"}, busy, 0);
    endtask

    logic [11:0] prog [4] = '{12'h012, 12'h131, 12'h243, 12'h354};

    initial begin
        tick(); tick();
        rst_n = 1;
        check("rst.valid", instr_valid, 0);
        check("rst.instr", instr_out, 0);
        check("rst.pc", pc_out, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.len", prog_len, 0);

        for (int i = 0; i < 4; i++) load_word(4'(i), prog[i]);
        check("basic.len", prog_len, 4);
        do_start();
        check("basic.busy", busy, 1);
        check("basic.first_gap", instr_valid, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_instr($sformatf("basic%0d", i), prog[i], 4'(i));
        end
        tick();
        expect_done("basic.end");

        do_start();
        tick(); expect_instr("stall0", 12'h012, 0);
        tick(); expect_instr("stall1", 12'h131, 1);
        instr_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_instr($sformatf("stall_hold%0d", i), 12'h131, 1);
        end
        instr_ready = 1;
        tick(); expect_instr("stall2", 12'h243, 2);
        tick(); expect_instr("stall3", 12'h354, 3);
        tick(); expect_done("stall.end");

        do_start();
        tick(); expect_instr("redir0", 12'h012, 0);
        tick(); expect_instr("redir1", 12'h131, 1);
        redirect_valid = 1; redirect_pc = 3;
        tick();
        redirect_valid = 0;
        check("redir.flush", instr_valid, 0);
        check("redir.busy", busy, 1);
        tick(); expect_instr("redir3", 12'h354, 3);
        tick(); expect_done("redir.end");

        do_start();
        tick(); expect_instr("redir9_0", 12'h012, 0);
        redirect_valid = 1; redirect_pc = 9;
        tick();
        redirect_valid = 0;
        expect_done("redir9");

        rst_n = 0; tick(); rst_n = 1;
        do_start();
        expect_done("empty");
        tick();
        check("empty.novalid", instr_valid, 0);
        load_word(5, 12'h555);
        check("empty.load_done", done, 0);
        check("empty.load_busy", busy, 0);
        check("empty.load_len", prog_len, 6);

        rst_n = 0; tick(); rst_n = 1;
        for (int i = 0; i < 16; i++) load_word(4'(i), 12'h0A0 + 12'(i));
        check("full.len", prog_len, 16);
        do_start();
        load_en = 1; load_addr = 0; load_data = 12'hFFF;
        for (int i = 0; i < 16; i++) begin
            tick();
            expect_instr($sformatf("full%0d", i), 12'h0A0 + 12'(i), 4'(i));
        end
        load_en = 0;
        tick(); expect_done("full.end");
        check("full.len_kept", prog_len, 16);

        do_start();
        tick(); expect_instr("noload0", 12'h0A0, 0);
        tick(); expect_instr("noload1", 12'h0A1, 1);
        rst_n = 0; tick(); rst_n = 1;
        check("midrst.valid", instr_valid, 0);
        check("midrst.busy", busy, 0);
        check("midrst.done", done, 0);
        check("midrst.len", prog_len, 0);

        load_en = 1; load_addr = 2; load_data = 12'h2AB; start = 1;
        tick();
        load_en = 0; start = 0;
        check("ldstart.busy", busy, 0);
        check("ldstart.done", done, 0);
        check("ldstart.len", prog_len, 3);
        do_start();
        tick(); expect_instr("reload0", 12'h0A0, 0);
        tick(); expect_instr("reload1", 12'h0A1, 1);
        tick(); expect_instr("reload2", 12'h2AB, 2);
        tick(); expect_done("reload.end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
